// File: rtl/kamikaze_memwb.sv
// kamikaze_memwb: memory-access/write-back stage with a single-outstanding data bus and a bypassed 32x32 register file
module kamikaze_memwb (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] result_i,
  input  logic [4:0]  rf_rd_i,
  input  logic        rf_rd_we_i,
  input  logic [1:0]  mem_op_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [31:0] rf [32];
  logic [4:0]  rd_q;
  logic        we_q;
  logic [1:0]  op_q;
  logic        mem_op, alu_we, ld_we;
  assign mem_op = valid_i & (mem_op_i == 2'b01 | mem_op_i == 2'b10);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = (state == IDLE) ? (mem_op ? WAIT : IDLE) : (dbus_ack_i ? IDLE : WAIT);
    stall_o = (state == IDLE) ? mem_op : !dbus_ack_i;
    alu_we  = state == IDLE & valid_i & !mem_op & rf_rd_we_i & rf_rd_i != 5'd0;
    ld_we   = state == WAIT & dbus_ack_i & op_q == 2'b01 & we_q & rd_q != 5'd0;
    wb_we_o   = alu_we | ld_we;
    wb_rd_o   = alu_we ? rf_rd_i : ld_we ? rd_q : 5'd0;
    wb_data_o = alu_we ? result_i : ld_we ? dbus_rdata_i : 32'd0;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_wdata_o <= '0;
      rd_q         <= '0;
      we_q         <= 1'b0;
      op_q         <= '0;
    end else if (state == IDLE && mem_op) begin
      dbus_req_o   <= 1'b1;
      dbus_we_o    <= mem_op_i == 2'b10;
      dbus_addr_o  <= result_i & ~32'd3;
      dbus_wdata_o <= store_data_i;
      rd_q         <= rf_rd_i;
      we_q         <= rf_rd_we_i;
      op_q         <= mem_op_i;
    end else if (state == WAIT && dbus_ack_i) begin
      dbus_req_o <= 1'b0;
      dbus_we_o  <= 1'b0;
    end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (wb_we_o) rf[wb_rd_o] <= wb_data_o;
  assign rs1_data_o = rs1_addr_i == 5'd0 ? 32'd0 : (wb_we_o && rs1_addr_i == wb_rd_o) ? wb_data_o : rf[rs1_addr_i];
  assign rs2_data_o = rs2_addr_i == 5'd0 ? 32'd0 : (wb_we_o && rs2_addr_i == wb_rd_o) ? wb_data_o : rf[rs2_addr_i];
endmodule
